// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with hold timeout and registered data mux
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATAW    = 8,
  parameter int MAX_HOLD = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          bus_req,
  output logic [NREQ-1:0]          bus_grant,
  input  logic [NREQ*DATAW-1:0]    data_in,
  input  logic [NREQ-1:0]          valid_in,
  output logic [DATAW-1:0]         bus_data,
  output logic                     bus_valid,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     ptr, ptr_nxt, owner_nxt, sel;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [NREQ-1:0]   grant_nxt;
  logic              tout_nxt, found, valid_nxt;
  logic [DATAW-1:0]  data_nxt;
  int                idx;

  // Rotating priority search starting at ptr, with explicit wrap for any NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus_req[idx]) begin
        found = 1'b1;
        sel   = OW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = bus_grant;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    tout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt      = sel;
          grant_nxt      = '0;
          grant_nxt[sel] = 1'b1;
          hold_nxt       = '0;
          state_nxt      = GRANT;
        end
      end
      GRANT: begin
        if (hold_cnt != {HW{1'b1}}) hold_nxt = hold_cnt + 1'b1;
        // A request drop wins over a coincident timeout and raises no error.
        if (!bus_req[owner]) begin
          grant_nxt = '0;
          state_nxt = RELEASE;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          grant_nxt = '0;
          tout_nxt  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        grant_nxt = '0;
        ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign valid_nxt = (state == GRANT) && valid_in[owner];
  assign data_nxt  = valid_nxt ? data_in[owner*DATAW +: DATAW] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_grant   <= '0;
      owner       <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      bus_valid   <= 1'b0;
      bus_data    <= '0;
    end else begin
      state       <= state_nxt;
      bus_grant   <= grant_nxt;
      owner       <= owner_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
      timeout_err <= tout_nxt;
      busy        <= (state_nxt != IDLE);
      bus_valid   <= valid_nxt;
      bus_data    <= data_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bus_req, req4, valid_in;
  logic [31:0] data_in;
  logic [3:0]  bus_grant, grant4;
  logic [7:0]  bus_data, data4;
  logic        bus_valid, valid4, busy, busy4, timeout_err, tout4;
  logic [1:0]  owner, owner4;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(4), .DATAW(8), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_grant(bus_grant),
    .data_in(data_in), .valid_in(valid_in), .bus_data(bus_data),
    .bus_valid(bus_valid), .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  bus_arbiter #(.NREQ(4), .DATAW(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .bus_req(req4), .bus_grant(grant4),
    .data_in(data_in), .valid_in(valid_in), .bus_data(data4),
    .bus_valid(valid4), .owner(owner4), .busy(busy4), .timeout_err(tout4)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int e;
    rst = 1'b1; bus_req = '0; req4 = '0; valid_in = '0; data_in = '0;
    tick(2);
    chk("rst_grant", 32'(bus_grant), 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_data", 32'(bus_data), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tout", 32'(timeout_err), 32'h0);
    rst = 1'b0;

    // single requester
    bus_req = 4'b0100;
    tick(1);
    chk("single_grant", 32'(bus_grant), 32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    tick(3);
    chk("single_hold", 32'(bus_grant), 32'h4);
    bus_req = 4'b0000;
    tick(1);
    chk("single_rel_grant", 32'(bus_grant), 32'h0);
    chk("single_rel_busy", 32'(busy), 32'h1);
    chk("single_rel_tout", 32'(timeout_err), 32'h0);
    tick(1);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // round robin, each owner drops after 3 grant cycles
    do_reset();
    bus_req = 4'b1111;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      chk("rr_grant", 32'(bus_grant), 32'(4'b0001 << e));
      chk("rr_owner", 32'(owner), 32'(e));
      tick(2);
      chk("rr_hold", 32'(bus_grant), 32'(4'b0001 << e));
      bus_req[e] = 1'b0;
      tick(1);
      chk("rr_gap_rel", 32'(bus_grant), 32'h0);
      bus_req[e] = 1'b1;
      tick(1);
      chk("rr_gap_idle", 32'(bus_grant), 32'h0);
      tick(1);
    end
    bus_req = '0;
    tick(2);

    // data mux
    do_reset();
    bus_req = 4'b0010;
    tick(1);
    chk("mux_owner", 32'(owner), 32'h1);
    bus_req = 4'b0011;
    data_in[15:8] = 8'hA1; data_in[7:0] = 8'hFF; valid_in = 4'b0011;
    tick(1);
    chk("mux_data_a1", 32'(bus_data), 32'hA1);
    chk("mux_valid", 32'(bus_valid), 32'h1);
    data_in[15:8] = 8'h5C;
    tick(1);
    chk("mux_data_5c", 32'(bus_data), 32'h5C);
    valid_in = 4'b0001;
    tick(1);
    chk("mux_nonowner_valid", 32'(bus_valid), 32'h0);
    chk("mux_nonowner_data", 32'(bus_data), 32'h0);
    valid_in = 4'b0010; data_in[15:8] = 8'h77; bus_req = 4'b0001;
    tick(1);
    chk("mux_last_grant", 32'(bus_grant), 32'h0);
    chk("mux_last_valid", 32'(bus_valid), 32'h1);
    chk("mux_last_data", 32'(bus_data), 32'h77);
    valid_in = '0; data_in = '0;
    tick(1);
    chk("mux_rel_valid", 32'(bus_valid), 32'h0);
    tick(1);
    chk("mux_next_grant", 32'(bus_grant), 32'h1);
    bus_req = '0;
    tick(2);

    // timeout with a competing request
    do_reset();
    bus_req = 4'b1010;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      chk("to_hold_grant", 32'(bus_grant), 32'h2);
      chk("to_hold_tout", 32'(timeout_err), 32'h0);
      tick(1);
    end
    chk("to_rel_grant", 32'(bus_grant), 32'h0);
    chk("to_pulse", 32'(timeout_err), 32'h1);
    tick(1);
    chk("to_pulse_end", 32'(timeout_err), 32'h0);
    tick(1);
    chk("to_next_grant", 32'(bus_grant), 32'h8);
    chk("to_next_owner", 32'(owner), 32'h3);
    bus_req = '0;
    tick(2);

    // mid-grant reset
    bus_req = 4'b0100;
    tick(1);
    chk("mr_grant", 32'(bus_grant), 32'h4);
    valid_in = 4'b0100; data_in[23:16] = 8'hAB;
    tick(1);
    chk("mr_valid_pre", 32'(bus_valid), 32'h1);
    rst = 1'b1; bus_req = 4'b0101;
    tick(1);
    chk("mr_grant_rst", 32'(bus_grant), 32'h0);
    chk("mr_valid_rst", 32'(bus_valid), 32'h0);
    chk("mr_tout_rst", 32'(timeout_err), 32'h0);
    chk("mr_owner_rst", 32'(owner), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("mr_after_grant", 32'(bus_grant), 32'h1);
    bus_req = '0; valid_in = '0; data_in = '0;
    tick(2);

    // drop exactly on the timeout cycle (MAX_HOLD=4 instance)
    req4 = 4'b0001;
    tick(1);
    chk("tie_grant", 32'(grant4), 32'h1);
    tick(3);
    chk("tie_hold4", 32'(grant4), 32'h1);
    req4 = '0;
    tick(1);
    chk("tie_rel_grant", 32'(grant4), 32'h0);
    chk("tie_no_tout", 32'(tout4), 32'h0);
    chk("tie_busy", 32'(busy4), 32'h1);
    tick(1);
    chk("tie_idle", 32'(busy4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
